// File: rtl/cla_pkg.sv
// Shared constants, parameter legality check and the generate/propagate pair
// used by the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_BLOCK  = 4;
    localparam int DEF_STAGES = 2;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Every slice must be a whole number of lookahead groups.
    function automatic bit cla_params_legal(int width, int block, int stages);
        return (width >= 4) && (width <= 64) &&
               (stages >= 1) && (stages <= 4) &&
               (block >= 1) && ((width % (block * stages)) == 0);
    endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for cla_addsub_pipe.
// The master drives operands and out_ready; the slave is the adder pipe.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = cla_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_block.sv
// One BLOCK-bit carry-lookahead group: sum bits from the group carry-in, plus
// the group generate/propagate pair for the next lookahead level.
module cla_block
    import cla_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             ci_i,
    output logic [BLOCK-1:0] s_o,
    output gp_t              gp_o
);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             g_acc;
    logic             p_acc;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Group G/P never look at ci_i, so the group-level chain has no loop.
    always_comb begin
        g_acc = 1'b0;
        p_acc = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            g_acc = g[i] | (p[i] & g_acc);
            p_acc = p_acc & p[i];
        end
    end

    assign gp_o.g = g_acc;
    assign gp_o.p = p_acc;

    // Bit carries inside the group; flattens to a two-level lookahead.
    always_comb begin
        c    = '0;
        c[0] = ci_i;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s_o = p ^ c[BLOCK-1:0];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage k adds slice k; the slice carry, finished low sum bits and the
// unconsumed high operand bits travel with the beat.
// Optional feature macro: CLA_ADDSUB_SAT_EN (signed saturation of sum on ovf).
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int BLOCK  = DEF_BLOCK,
    parameter int STAGES = DEF_STAGES
) (
    input logic              clk,
    input logic              rst,
    cla_addsub_pipe_if.slave bus
);
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / BLOCK;
    localparam int L  = STAGES - 1;

    if (!cla_params_legal(WIDTH, BLOCK, STAGES)) begin : g_illegal
        $error("cla_addsub_pipe: illegal WIDTH/BLOCK/STAGES combination");
    end

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] vin;
    logic [STAGES:0]   adv;
    logic              rdy_q;
    logic              in_fire;

    // A stage moves when it is empty or its successor moves.
    always_comb begin
        adv         = '0;
        adv[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = ~v_q[k] | adv[k+1];
        end
    end

    // rdy_q keeps in_ready low until the first edge after reset release.
    assign bus.in_ready = rdy_q & adv[0];
    assign in_fire      = bus.in_valid & bus.in_ready;

    // Valid bits shift on advance; an empty stage takes a bubble, collapsing gaps.
    always_comb begin
        vin    = '0;
        vin[0] = in_fire;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = adv[k] ? vin[k] : v_q[k];
        end
    end

    // Valid/ready state; reset discards any beats in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            rdy_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            rdy_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int HW = WIDTH - k * SW;   // operand bits from this slice up
        localparam int LW = (k + 1) * SW;     // sum bits finished after this stage

        logic [HW-1:0] a_src;
        logic [HW-1:0] bx_src;
        logic          c_src;
        logic [SW-1:0] slc_s;
        logic [NG:0]   gc;
        gp_t           gp [NG];
        logic [LW-1:0] s_d;
        logic [LW-1:0] s_q;
        logic          c_q;

        if (k == 0) begin : g_in
            // Subtract is a + ~b + ~cin, so invert once at the input.
            assign a_src  = bus.a;
            assign bx_src = bus.sub ? ~bus.b : bus.b;
            assign c_src  = bus.sub ? ~bus.cin : bus.cin;
            assign s_d    = slc_s;
        end else begin : g_mid
            assign a_src  = g_stg[k-1].g_fwd.a_q;
            assign bx_src = g_stg[k-1].g_fwd.bx_q;
            assign c_src  = g_stg[k-1].c_q;
            assign s_d    = {slc_s, g_stg[k-1].s_q};
        end

        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_block #(.BLOCK(BLOCK)) u_blk (
                .a_i  (a_src[j*BLOCK +: BLOCK]),
                .b_i  (bx_src[j*BLOCK +: BLOCK]),
                .ci_i (gc[j]),
                .s_o  (slc_s[j*BLOCK +: BLOCK]),
                .gp_o (gp[j])
            );
        end

        // Group-level lookahead across the slice.
        always_comb begin
            gc    = '0;
            gc[0] = c_src;
            for (int j = 0; j < NG; j++) begin
                gc[j+1] = gp[j].g | (gp[j].p & gc[j]);
            end
        end

        // Slice result and inter-slice carry register.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv[k] && vin[k]) begin
                s_q <= s_d;
                c_q <= gc[NG];
            end
        end

        if (k < L) begin : g_fwd
            logic [HW-SW-1:0] a_q;
            logic [HW-SW-1:0] bx_q;

            // High operand bits not consumed yet ride along with the beat.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_q  <= '0;
                    bx_q <= '0;
                end else if (adv[k] && vin[k]) begin
                    a_q  <= a_src[HW-1:SW];
                    bx_q <= bx_src[HW-1:SW];
                end
            end
        end else begin : g_last
            logic o_d;
            logic o_q;

            assign o_d = (a_src[HW-1] == bx_src[HW-1]) && (s_d[LW-1] != a_src[HW-1]);

            // Signed overflow needs the operand signs, known only in the top slice.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    o_q <= 1'b0;
                end else if (adv[k] && vin[k]) begin
                    o_q <= o_d;
                end
            end
        end
    end

    assign bus.out_valid = v_q[L];
    assign bus.cout      = g_stg[L].c_q;
    assign bus.ovf       = g_stg[L].g_last.o_q;

`ifdef CLA_ADDSUB_SAT_EN
    // On overflow the operand sign is the inverse of the wrapped sum sign.
    always_comb begin
        if (g_stg[L].g_last.o_q) begin
            bus.sum = {~g_stg[L].s_q[WIDTH-1], {(WIDTH-1){g_stg[L].s_q[WIDTH-1]}}};
        end else begin
            bus.sum = g_stg[L].s_q;
        end
    end
`else
    assign bus.sum = g_stg[L].s_q;
`endif

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe (WIDTH=16, BLOCK=4, STAGES=2): vector table,
// stall/reset sequences and a random stream against a reference model.
module tb_cla_addsub_pipe;
    localparam int W = 16;
`ifdef CLA_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cla_addsub_pipe_if #(.WIDTH(W)) bus ();

    cla_addsub_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          recv  = 0;
    logic [17:0] sbq[$];
    logic        stall_seen = 1'b0;
    logic [17:0] held = '0;
    vec_t        vecs[10];

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic cin);
        logic [15:0] bx;
        logic        ci;
        logic [16:0] r;
        logic [15:0] s;
        logic        o;
        bx = sub ? ~b : b;
        ci = sub ? ~cin : cin;
        r  = {1'b0, a} + {1'b0, bx} + {16'b0, ci};
        o  = (a[15] == bx[15]) && (r[15] != a[15]);
        s  = r[15:0];
        if (SAT && o) s = a[15] ? 16'h8000 : 16'h7FFF;
        return {s, r[16], o};
    endfunction

    function automatic logic [15:0] pick();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h0000;
            1: v = 16'hFFFF;
            2: v = 16'h7FFF;
            3: v = 16'h8000;
            4: v = 16'h00FF;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept, pop on consume, and watch held outputs.
    always @(negedge clk) begin
        if (!rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'({bus.sum, bus.cout, bus.ovf}), 32'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got %0h with nothing outstanding", {bus.sum, bus.cout, bus.ovf});
                end else begin
                    check("stream", 32'({bus.sum, bus.cout, bus.ovf}), 32'(sbq.pop_front()));
                    recv++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                sbq.push_back(model(bus.a, bus.b, bus.sub, bus.cin));
            stall_seen = bus.out_valid && !bus.out_ready;
            held       = {bus.sum, bus.cout, bus.ovf};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int sent;
        int cycles;
        int recv0;
        logic ok;

        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
        vecs[1] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b1, 1'b0, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[6] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};
        vecs[9] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        #9 rst = 1'b1;
        step();
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Vector table: exact latency and values
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.a        = vecs[i].a;
            bus.b        = vecs[i].b;
            bus.sub      = vecs[i].sub;
            bus.cin      = vecs[i].cin;
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_early", i), 32'(bus.out_valid), 32'd0);
            step();
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d_sum", i), 32'(bus.sum), 32'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vecs[i].co));
            check($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].ov));
            step();
        end

        // Back-to-back beats into a stalled output
        bus.out_ready = 1'b0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        acc           = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            bus.a        = 16'(acc + 1);
            bus.b        = 16'(acc + 1);
            bus.in_valid = 1'b1;
            @(negedge clk);
            ok = bus.in_ready;
            step();
            if (ok) acc++;
        end
        check("stall_accepts", 32'(acc), 32'd2);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_sum", 32'(bus.sum), 32'h0002);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("drain%0d_sum", k), 32'(bus.sum), 32'(2 * (k + 1)));
            if (acc < 4) begin
                bus.a        = 16'(acc + 1);
                bus.b        = 16'(acc + 1);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            ok = bus.in_valid && bus.in_ready;
            step();
            if (ok) acc++;
        end
        bus.in_valid = 1'b0;
        check("drain_empty", 32'(bus.out_valid), 32'd0);

        // Reset with two beats in flight
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.a        = 16'h0010 * 16'(k + 1);
            bus.b        = 16'h0001;
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        check("mid_full", 32'(bus.out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        sbq.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        step();
        check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("no_stale%0d", k), 32'(bus.out_valid), 32'd0);
            step();
        end

        // Random stream
        recv0  = recv;
        sent   = 0;
        cycles = 0;
        while (sent < 10000 && cycles < 60000) begin
            if (!bus.in_valid && $urandom_range(0, 9) < 7) begin
                bus.a        = pick();
                bus.b        = pick();
                bus.sub      = 1'($urandom);
                bus.cin      = 1'($urandom);
                bus.in_valid = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            ok = bus.in_valid && bus.in_ready;
            step();
            cycles++;
            if (ok) begin
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && sbq.size() > 0; k++) step();
        step();
        check("rand_sent", 32'(sent), 32'd10000);
        check("rand_recv", 32'(recv - recv0), 32'd10000);
        check("rand_left", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_addsub_pipe.md
CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits; legal values are 4..64 and multiples of BLOCK*STAGES.
REQ-002 The block SHALL have parameter BLOCK, default 4, lookahead group width in bits.
REQ-003 The block SHALL have parameter STAGES, default 2, pipeline register stages; legal values are 1..4.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operand beat valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a beat.
REQ-008 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects a+b+cin; 1 selects a-b-cin (borrow-in).
REQ-010 The block SHALL have port cin, input, 1 bit: carry-in, or borrow-in when sub=1.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result beat valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: result.
REQ-014 The block SHALL have port cout, output, 1 bit: carry-out; for subtract, 1 means no borrow.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 A beat SHALL be accepted on a clk edge where in_valid=1 and in_ready=1; a result SHALL be consumed on an edge where out_valid=1 and out_ready=1.
REQ-017 Subtract SHALL be computed as a + ~b + ~cin; the result and cout SHALL be taken modulo 2^WIDTH with carry out of the MSB.
REQ-018 ovf SHALL be set when the operand signs (b inverted for subtract) are equal and differ from the sign of sum.
REQ-019 The carry chain SHALL be split into STAGES equal slices; slice k SHALL use BLOCK-bit lookahead groups with a group-level lookahead carry; the carry between slices SHALL be registered.
REQ-020 Low slices already computed and high operand bits not yet consumed SHALL be delayed alongside the beat, so a beat's sum is bit-exact.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready=1 throughout; throughput SHALL be one beat per cycle.
REQ-022 Each stage SHALL hold a valid bit; a stage SHALL advance when it is empty or the next stage advances.
REQ-023 in_ready SHALL be 1 when stage 0 is empty or advancing; in_ready SHALL not depend combinationally on in_valid.
REQ-024 With out_ready=0 and out_valid=1, sum, cout and ovf SHALL be held stable; no beat SHALL be lost, duplicated or reordered.
REQ-025 Interior bubbles SHALL collapse while the output stalls.
REQ-026 Simultaneous consume at the output and accept at the input on a full pipe SHALL proceed with no bubble.

Reset
REQ-027 While rst=0, all stage valid bits, out_valid, sum, cout and ovf SHALL be 0 immediately, independent of clk.
REQ-028 In-flight beats SHALL be discarded on reset.
REQ-029 in_ready SHALL be 0 during reset and 1 on the first edge after rst is released.

Configuration
REQ-030 The block SHALL support macro CLA_ADDSUB_SAT_EN.
REQ-031 When CLA_ADDSUB_SAT_EN is defined and ovf=1, sum SHALL be clamped to the signed maximum (operand signs positive) or the signed minimum (negative); ovf SHALL still report 1 and cout SHALL be unchanged.
REQ-032 When CLA_ADDSUB_SAT_EN is undefined, sum SHALL wrap and no saturation logic SHALL be present.

Structure
REQ-033 Package cla_pkg SHALL hold the default WIDTH/BLOCK/STAGES constants, the parameter-legality check function, and the generate/propagate pair typedef.
REQ-034 Sub-module cla_block SHALL be the combinational BLOCK-bit lookahead group producing sum bits, group G and group P; it SHALL be instanced per group.
REQ-035 The top SHALL contain only slicing, pipeline registers, handshake logic and the optional saturation.
REQ-036 An illegal parameter combination SHALL fail elaboration.

Verification
All scenarios use WIDTH=16, BLOCK=4, STAGES=2.
REQ-037 Assert rst=0 mid-stream with 2 beats in flight -> out_valid=0 and sum=0 at once; in_ready=1 on the first edge after release; no stale beat emerges.
REQ-038 a=0x7FFF, b=0x0001, sub=0, cin=0, out_ready=1 -> exactly 2 cycles after acceptance: sum=0x8000, cout=0, ovf=1; with CLA_ADDSUB_SAT_EN: sum=0x7FFF, ovf=1.
REQ-039 a=0x0003, b=0x0005, sub=1, cin=0 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-040 a=0xFFFF, b=0xFFFF, sub=0, cin=1 -> sum=0xFFFF, cout=1, ovf=0; a=0x00FF, b=0x0001 -> sum=0x0100, checking the carry across the slice boundary.
REQ-041 Present 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts; held output stays 0x0002; on release the outputs are 0x0002, 0x0004, 0x0006, 0x0008 in order, one per cycle.
REQ-042 A 10,000-beat random stream with random in_valid/out_ready, checked against a reference model -> zero mismatches, zero drops, order preserved.
